gift_enc_control: RTL

Control FSM for the GIFT-128 encryption datapath; it is the encrypt-direction counterpart of the decryption controller. It gates external key/data loads, then sequences ROUNDS round/key-schedule updates while generating the 6-bit round constant on-the-fly. No key memory is needed. The result is captured into the output register and held valid until the host acknowledges it. It sits between the host write/read strobes and the round register, key-schedule register and data-out register.

---
 rtl/gift_pkg.sv | 22 ++
 rtl/gift_round_const_lfsr.sv | 32 +++
 rtl/gift_enc_control.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/gift_pkg.sv
// Shared types and constants for the GIFT-128 encryption controller.
// Holds the FSM state encoding and the round-constant update rule.
package gift_pkg;

    localparam int GIFT_RC_WIDTH  = 6;
    localparam int GIFT128_ROUNDS = 40;
    localparam logic [GIFT_RC_WIDTH-1:0] GIFT_RC_INIT = 6'h01;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_STORE = 3'd3,
        ST_HOLD  = 3'd4
    } gift_state_e;

    // Shift left, feeding in the complement of the XOR of the top two bits.
    function automatic logic [GIFT_RC_WIDTH-1:0] gift_rc_next(input logic [GIFT_RC_WIDTH-1:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/gift_round_const_lfsr.sv
// 6-bit GIFT round-constant LFSR: synchronous load of the initial constant,
// one step per enabled cycle, asynchronous clear.
module gift_round_const_lfsr
    import gift_pkg::*;
#(
    parameter logic [GIFT_RC_WIDTH-1:0] RC_INIT = GIFT_RC_INIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     step,
    output logic [GIFT_RC_WIDTH-1:0] rc
);

    logic [GIFT_RC_WIDTH-1:0] rc_r;

    // Constant register: load takes priority over stepping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rc_r <= {GIFT_RC_WIDTH{1'b0}};
        end else if (load) begin
            rc_r <= RC_INIT;
        end else if (step) begin
            rc_r <= gift_rc_next(rc_r);
        end else begin
            rc_r <= rc_r;
        end
    end

    assign rc = rc_r;

endmodule

// File: rtl/gift_enc_control.sv
// Control FSM for the GIFT-128 encryption datapath: gates host loads,
// sequences the rounds with on-the-fly constants and holds the result valid.
module gift_enc_control
    import gift_pkg::*;
#(
    parameter int                       ROUNDS  = GIFT128_ROUNDS,
    parameter logic [GIFT_RC_WIDTH-1:0] RC_INIT = GIFT_RC_INIT
) (
    input  logic                     inClk,
    input  logic                     inRst,
    input  logic                     inExtKeyWr,
    input  logic                     inExtDataWr,
    input  logic                     inExtDataRd,
    output logic                     outIntKeyschRegExtWr,
    output logic                     outIntKeyschRegRestore,
    output logic                     outIntKeyschRegIntWr,
    output logic                     outIntRoundRegExtWr,
    output logic                     outIntRoundRegIntWr,
    output logic [GIFT_RC_WIDTH-1:0] outIntRoundConst,
    output logic [7:0]               outIntRoundIdx,
    output logic                     outIntDataOutRegWr,
    output logic                     outDataValid,
    output logic                     outBusy
);

    localparam logic [7:0] LAST_IDX = 8'(ROUNDS - 1);

    gift_state_e              state_r;
    gift_state_e              state_next_s;
    logic [7:0]               round_cnt_r;
    logic [GIFT_RC_WIDTH-1:0] rc_s;
    logic                     valid_r;
    logic                     busy_r;

    gift_round_const_lfsr #(.RC_INIT(RC_INIT)) u_rc (
        .clk  (inClk),
        .rst  (inRst),
        .load (state_r == ST_LOAD),
        .step (state_r == ST_ROUND),
        .rc   (rc_s)
    );

    // State register.
    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a data write in HOLD beats a simultaneous read.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  state_next_s = inExtDataWr ? ST_LOAD : ST_IDLE;
            ST_LOAD:  state_next_s = ST_ROUND;
            ST_ROUND: state_next_s = (round_cnt_r == LAST_IDX) ? ST_STORE : ST_ROUND;
            ST_STORE: state_next_s = ST_HOLD;
            ST_HOLD: begin
                if (inExtDataWr) begin
                    state_next_s = ST_LOAD;
                end else if (inExtDataRd) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Datapath strobes; host strobes pass through only in IDLE and HOLD.
    always_comb begin
        outIntKeyschRegExtWr   = 1'b0;
        outIntKeyschRegRestore = 1'b0;
        outIntKeyschRegIntWr   = 1'b0;
        outIntRoundRegExtWr    = 1'b0;
        outIntRoundRegIntWr    = 1'b0;
        outIntRoundConst       = {GIFT_RC_WIDTH{1'b0}};
        outIntRoundIdx         = 8'd0;
        outIntDataOutRegWr     = 1'b0;
        case (state_r)
            ST_IDLE, ST_HOLD: begin
                outIntKeyschRegExtWr = inExtKeyWr;
                outIntRoundRegExtWr  = inExtDataWr;
            end
            ST_LOAD: outIntKeyschRegRestore = 1'b1;
            ST_ROUND: begin
                outIntKeyschRegIntWr = 1'b1;
                outIntRoundRegIntWr  = 1'b1;
                outIntRoundConst     = rc_s;
                outIntRoundIdx       = round_cnt_r;
            end
            ST_STORE: outIntDataOutRegWr = 1'b1;
            default: begin
                outIntKeyschRegExtWr = 1'b0;
            end
        endcase
    end

    // Round counter: cleared in LOAD, advanced once per round.
    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            round_cnt_r <= 8'd0;
        end else if (state_r == ST_LOAD) begin
            round_cnt_r <= 8'd0;
        end else if (state_r == ST_ROUND) begin
            round_cnt_r <= round_cnt_r + 8'd1;
        end else begin
            round_cnt_r <= round_cnt_r;
        end
    end

    // Host status flags.
    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_HOLD: begin
                    if (inExtDataWr) begin
                        valid_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end else if (inExtDataRd) begin
                        valid_r <= 1'b0;
                    end
                end
                ST_STORE: begin
                    valid_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
                default: begin
                    valid_r <= valid_r;
                    busy_r  <= busy_r;
                end
            endcase
        end
    end

    assign outDataValid = valid_r;
    assign outBusy      = busy_r;

endmodule
